bram_selftest: RTL and testbench
================================

# bram_selftest

Parametrised block-RAM write/readback self-test for the VSDSquadron FM fabric. It infers one synchronous-read RAM of `2**ADDR_W` words × `DATA_W` bits and fills every address from a selectable pattern generator. It then reads every address back through the registered read port, compares against the regenerated pattern, and reports pass/fail, error count and first failing address. A fault-injection path exercises the fail logic. It sits at top level as a bring-up/regression block whose status drives a board I/O.

## Interface
- `DATA_W`, 8, RAM word width (≥2).
- `ADDR_W`, 8, address width; depth `DEPTH = 2**ADDR_W`.
- `hw_clk` input 1, single system clock, all logic on rising edge.
- `rst_n` input 1, asynchronous active-low reset.
- `start` input 1, begins a run when sampled high in IDLE or DONE.
- `pattern` input 2, pattern select, sampled with `start`.
- `seed` input DATA_W, pattern-2 offset, sampled with `start`.
- `inject_en` input 1, enables fault injection, sampled with `start`.
- `inject_addr` input ADDR_W, address whose written word has bit 0 inverted, sampled with `start`.
- `busy` output 1, high in WRITE/READ/DRAIN.
- `done` output 1, high in DONE.
- `pass` output 1, `done && err_count==0`.
- `err_count` output ADDR_W+1, mismatching words in the last run (0..DEPTH, no saturation needed).
- `first_err_addr` output ADDR_W, lowest mismatching address; 0 if none.
- `io0` output 1, board status = `pass`.

## Operation
- Pattern `pat(a)`, result mod 2^DATA_W, with `a` zero-extended or truncated to DATA_W:
  - 0: `a`.
  - 1: `~a`.
  - 2: `seed + a`.
  - 3: `{10}` replicated (MSB-first, truncated) for even `a`, `{01}` replicated for odd `a`.
- Write data = `pat(a) ^ 1` when `inject_en && a==inject_addr`, else `pat(a)`. Comparison always uses `pat(a)`.
- States: IDLE → WRITE → READ → DRAIN → DONE.
  - IDLE/DONE + `start` → WRITE. Address counter, `err_count`, `first_err_addr` and the first-error flag clear; inputs are latched.
  - WRITE: one write per cycle, address 0..DEPTH-1 ascending. After the last address → READ.
  - READ: one read address per cycle, 0..DEPTH-1. The RAM read is registered (1-cycle latency). Expected value and address are delayed by one stage to align with read data. The compare result is registered one further stage, then accumulated. After the last address → DRAIN.
  - DRAIN: 2 cycles to flush the read and compare stages → DONE.
  - DONE: results held until next `start`.
- `start` in WRITE/READ/DRAIN is ignored.
- On a mismatch, `err_count` increments. On the first mismatch of a run only, `first_err_addr` loads the aligned address.
- RAM contents are not reset and not cleared between runs.

## Timing
- Reset values: state IDLE; `busy`, `done`, `pass`, `io0`, `err_count`, `first_err_addr` all 0.
- Reset asserted mid-run aborts immediately to IDLE with reset values. The run is not resumed.
- Take edge 0 as the edge sampling `start`:
  - `busy` = 1 from edge 0.
  - Writes commit at edges 1..DEPTH.
  - Read data for address k is valid after edge DEPTH+1+k.
  - Accumulation for address k occurs at edge DEPTH+2+k.
  - `busy` falls and `done` rises at edge 2·DEPTH+2.
  - `err_count`/`first_err_addr` are final by that edge.
- Restart from DONE: `done` falls at the sampling edge; same timeline.
- No read-during-write hazard: write and read phases never overlap.

## Test plan
- Default params, `pattern`=0, no inject, pulse `start` → `done` at edge 514 exactly, `pass`=1, `err_count`=0, `io0`=1, `busy` high edges 0..513.
- `pattern`=2, `seed`=8'h0E, `inject_en`=1, `inject_addr`=3 → `err_count`=1, `first_err_addr`=3, `pass`=0, `io0`=0. RAM[3] reads 8'h10.
- `ADDR_W`=4, `DATA_W`=8, `pattern`=3, then `pattern`=1 back-to-back restart from DONE → each run `done` at edge 34, `pass`=1; RAM[5]=8'hFA after second run.
- Pulse `start` again at edges 10 and 300 of a run → ignored, timeline unchanged.
- Assert `rst_n` low at edge 100 (mid-WRITE) → all outputs 0 asynchronously, state IDLE. A new `start` gives a full clean run with `pass`=1.
- Inject at `inject_addr`=DEPTH-1 (255) → `err_count`=1, `first_err_addr`=255. This checks last-address alignment through DRAIN.

Source files
------------

// File: rtl/bram_selftest.sv
// Block-RAM write/readback self-test: fills the RAM from a pattern generator,
// reads it back through the registered port and reports pass/fail status.
module bram_selftest #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        pattern,
  input  logic [DATA_W-1:0] seed,
  input  logic              inject_en,
  input  logic [ADDR_W-1:0] inject_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              io0
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct packed {
    logic [1:0]        pattern;
    logic [DATA_W-1:0] seed;
    logic              inject_en;
    logic [ADDR_W-1:0] inject_addr;
  } cfg_t;

  // Address is zero-extended or truncated to the word width before use.
  function automatic logic [DATA_W-1:0] pat_f(input logic [1:0]        sel,
                                              input logic [DATA_W-1:0] sd,
                                              input logic [ADDR_W-1:0] a);
    logic [DATA_W+ADDR_W-1:0] wide;
    logic [DATA_W-1:0]        ax;
    logic [DATA_W-1:0]        alt;
    wide = {{DATA_W{1'b0}}, a};
    ax   = wide[DATA_W-1:0];
    alt  = '0;
    for (int i = 0; i < DATA_W; i++) alt[i] = (((DATA_W-1-i) % 2) == 0) ^ a[0];
    case (sel)
      2'd0:    pat_f = ax;
      2'd1:    pat_f = ~ax;
      2'd2:    pat_f = sd + ax;
      default: pat_f = alt;
    endcase
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  cfg_t              cfg_q, cfg_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic              seen_q, seen_d;
  logic              drain_q, drain_d;

  // Read-alignment stage: expected word and address travel with the RAM read.
  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] eaddr_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  logic [DATA_W-1:0] pat_cur;
  logic [DATA_W-1:0] wdata;
  logic              we, re, last, mismatch;

  always_comb begin
    pat_cur  = pat_f(cfg_q.pattern, cfg_q.seed, addr_q);
    wdata    = pat_cur ^ {{(DATA_W-1){1'b0}},
                          (cfg_q.inject_en && (addr_q == cfg_q.inject_addr))};
    we       = (state_q == S_WRITE);
    re       = (state_q == S_READ);
    last     = &addr_q;
    mismatch = vld_q && (rd_q != exp_q);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cfg_d   = cfg_q;
    err_d   = err_q;
    fea_d   = fea_q;
    seen_d  = seen_q;
    drain_d = drain_q;

    if (mismatch) begin
      err_d = err_q + (ADDR_W+1)'(1);
      if (!seen_q) begin
        fea_d  = eaddr_q;
        seen_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d           = S_WRITE;
          addr_d            = '0;
          err_d             = '0;
          fea_d             = '0;
          seen_d            = 1'b0;
          cfg_d.pattern     = pattern;
          cfg_d.seed        = seed;
          cfg_d.inject_en   = inject_en;
          cfg_d.inject_addr = inject_addr;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last) state_d = S_READ;
      end
      S_READ: begin
        addr_d  = addr_q + ADDR_W'(1);
        drain_d = 1'b0;
        if (last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cfg_q   <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      seen_q  <= 1'b0;
      drain_q <= 1'b0;
      vld_q   <= 1'b0;
      exp_q   <= '0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      seen_q  <= seen_d;
      drain_q <= drain_d;
      vld_q   <= re;
      exp_q   <= pat_cur;
      eaddr_q <= addr_q;
    end
  end

  // RAM contents are deliberately left unreset so the array maps to block RAM.
  always_ff @(posedge hw_clk) begin
    if (we) mem_q[addr_q] <= wdata;
    if (re) rd_q <= mem_q[addr_q];
  end

  always_comb begin
    busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    done           = (state_q == S_DONE);
    pass           = done && (err_q == '0);
    err_count      = err_q;
    first_err_addr = fea_q;
    io0            = pass;
  end

endmodule

// File: tb/tb_bram_selftest.sv
// Scoreboarded random bench for bram_selftest: a default-size and a 16-word instance.
module tb_bram_selftest;

  logic hw_clk = 1'b0;
  logic rst_n  = 1'b1;
  always #5 hw_clk = ~hw_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge hw_clk) cyc <= cyc + 1;

  logic       a_start = 0, a_inj = 0;
  logic [1:0] a_pattern = 0;
  logic [7:0] a_seed = 0, a_iaddr = 0;
  logic       a_busy, a_done, a_pass, a_io0;
  logic [8:0] a_err;
  logic [7:0] a_fea;

  logic       b_start = 0, b_inj = 0;
  logic [1:0] b_pattern = 0;
  logic [7:0] b_seed = 0;
  logic [3:0] b_iaddr = 0;
  logic       b_busy, b_done, b_pass, b_io0;
  logic [4:0] b_err;
  logic [3:0] b_fea;

  bram_selftest #(.DATA_W(8), .ADDR_W(8)) dut_a (
    .hw_clk(hw_clk), .rst_n(rst_n), .start(a_start), .pattern(a_pattern),
    .seed(a_seed), .inject_en(a_inj), .inject_addr(a_iaddr), .busy(a_busy),
    .done(a_done), .pass(a_pass), .err_count(a_err), .first_err_addr(a_fea),
    .io0(a_io0));

  bram_selftest #(.DATA_W(8), .ADDR_W(4)) dut_b (
    .hw_clk(hw_clk), .rst_n(rst_n), .start(b_start), .pattern(b_pattern),
    .seed(b_seed), .inject_en(b_inj), .inject_addr(b_iaddr), .busy(b_busy),
    .done(b_done), .pass(b_pass), .err_count(b_err), .first_err_addr(b_fea),
    .io0(b_io0));

  typedef struct {
    int done_edge;
    int err;
    int fea;
    int pass;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference pattern: plain arithmetic on the word value.
  function automatic int pat_m(input int sel, input int sd, input int a, input int dw);
    int m, ax, v;
    m  = 1 << dw;
    ax = a % m;
    v  = 0;
    case (sel)
      0: v = ax;
      1: v = m - 1 - ax;
      2: v = (sd + ax) % m;
      default: for (int p = dw - 1 - (a % 2); p >= 0; p -= 2) v += (1 << p);
    endcase
    return v;
  endfunction

  function automatic void model(input int depth, input int dw, input int sel, input int sd,
                                input int inj, input int ia, output int err, output int fea);
    int mem[];
    mem = new[depth];
    err = 0;
    fea = 0;
    for (int a = 0; a < depth; a++)
      mem[a] = pat_m(sel, sd, a, dw) ^ ((inj != 0 && a == ia) ? 1 : 0);
    for (int a = 0; a < depth; a++)
      if (mem[a] != pat_m(sel, sd, a, dw)) begin
        if (err == 0) fea = a;
        err++;
      end
  endfunction

  // Monitors: compare result fields whenever done rises.
  logic a_done_q = 0, b_done_q = 0;
  always @(negedge hw_clk) begin
    exp_t e;
    if (a_done && !a_done_q) begin
      if (sb_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        e = sb_a.pop_front();
        chk("a_done_edge", cyc, e.done_edge);
        chk("a_err_count", a_err, e.err);
        chk("a_first_err_addr", a_fea, e.fea);
        chk("a_pass", a_pass, e.pass);
        chk("a_io0", a_io0, e.pass);
      end
    end
    a_done_q <= a_done;
  end

  always @(negedge hw_clk) begin
    exp_t e;
    if (b_done && !b_done_q) begin
      if (sb_b.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        e = sb_b.pop_front();
        chk("b_done_edge", cyc, e.done_edge);
        chk("b_err_count", b_err, e.err);
        chk("b_first_err_addr", b_fea, e.fea);
        chk("b_pass", b_pass, e.pass);
        chk("b_io0", b_io0, e.pass);
      end
    end
    b_done_q <= b_done;
  end

  task automatic run_a(input int sel, input int sd, input int inj, input int ia,
                       input bit spur, input int rst_at);
    int e0, err, fea, n;
    exp_t e;
    @(negedge hw_clk);
    a_pattern = sel[1:0];
    a_seed    = sd[7:0];
    a_inj     = inj[0];
    a_iaddr   = ia[7:0];
    a_start   = 1'b1;
    e0 = cyc + 1;
    model(256, 8, sel, sd, inj, ia, err, fea);
    e.done_edge = e0 + 2 * 256 + 2;
    e.err = err;
    e.fea = fea;
    e.pass = (err == 0) ? 1 : 0;
    sb_a.push_back(e);
    n = 0;
    while (n == 0 || !a_done) begin
      @(negedge hw_clk);
      n++;
      a_start = spur && ((cyc + 1 == e0 + 10) || (cyc + 1 == e0 + 300));
      if (cyc == e0) chk("a_busy_edge0", {a_busy, a_done}, 2'b10);
      if (cyc == e0 + 513) chk("a_busy_edge513", {a_busy, a_done}, 2'b10);
      if (rst_at >= 0 && cyc == e0 + rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("a_async_reset", {a_busy, a_done, a_pass, a_io0, a_err, a_fea}, 0);
        sb_a.delete();
        @(negedge hw_clk);
        rst_n = 1'b1;
        return;
      end
      if (n > 600) break;
    end
    chk("a_done_seen", a_done, 1);
    chk("a_busy_at_done", a_busy, 0);
  endtask

  task automatic run_b(input int sel, input int sd, input int inj, input int ia);
    int e0, err, fea, n;
    exp_t e;
    @(negedge hw_clk);
    b_pattern = sel[1:0];
    b_seed    = sd[7:0];
    b_inj     = inj[0];
    b_iaddr   = ia[3:0];
    b_start   = 1'b1;
    e0 = cyc + 1;
    model(16, 8, sel, sd, inj, ia, err, fea);
    e.done_edge = e0 + 2 * 16 + 2;
    e.err = err;
    e.fea = fea;
    e.pass = (err == 0) ? 1 : 0;
    sb_b.push_back(e);
    n = 0;
    while (n == 0 || !b_done) begin
      @(negedge hw_clk);
      n++;
      b_start = 1'b0;
      if (cyc == e0) chk("b_busy_edge0", {b_busy, b_done}, 2'b10);
      if (n > 100) break;
    end
    chk("b_done_seen", b_done, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge hw_clk);
    chk("a_reset_state", {a_busy, a_done, a_pass, a_io0, a_err, a_fea}, 0);
    chk("b_reset_state", {b_busy, b_done, b_pass, b_io0, b_err, b_fea}, 0);
    rst_n = 1'b1;

    run_b(3, 0, 0, 0);
    run_b(1, 0, 0, 0);
    chk("b_ram5", dut_b.mem_q[5], pat_m(1, 0, 5, 8));
    chk("b_ram5_const", dut_b.mem_q[5], 8'hFA);

    run_a(0, 0, 0, 0, 1'b0, -1);
    run_a(2, 8'h0E, 1, 3, 1'b0, -1);
    chk("a_ram3", dut_a.mem_q[3], pat_m(2, 8'h0E, 3, 8) ^ 1);
    run_a(1, 0, 0, 0, 1'b1, -1);
    run_a(0, 0, 0, 0, 1'b0, 100);
    run_a(0, 0, 0, 0, 1'b0, -1);
    run_a(0, 0, 1, 255, 1'b0, -1);

    for (int i = 0; i < 4; i++)
      run_a($urandom_range(3, 0), $urandom_range(255, 0), $urandom_range(1, 0),
            $urandom_range(255, 0), 1'b0, -1);
    for (int i = 0; i < 3; i++)
      run_b($urandom_range(3, 0), $urandom_range(255, 0), $urandom_range(1, 0),
            $urandom_range(15, 0));

    repeat (3) @(negedge hw_clk);
    chk("a_scoreboard_empty", sb_a.size(), 0);
    chk("b_scoreboard_empty", sb_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
